// File: rtl/edge_cap_pkg.sv
// Shared types and constants for the edge frame capture block.
package edge_cap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_CAPTURE,
        ST_DONE
    } cap_state_t;

    localparam int EDGE_BIT = 7;

    function automatic int ceil_div8(input int n);
        return (n + 7) / 8;
    endfunction

endpackage

// File: rtl/edge_bit_packer.sv
// Packs a stream of single-bit pixels into 8-bit words, bit 0 leftmost,
// flushing a zero-padded partial word at line end.
module edge_bit_packer
    import edge_cap_pkg::*;
#(
    parameter int WPL    = 22,
    parameter int WIDX_W = $clog2(WPL + 1)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clear,
    input  logic              bit_valid,
    input  logic              bit_in,
    input  logic              line_end,
    output logic              word_valid,
    output logic [7:0]        word_data,
    output logic [WIDX_W-1:0] word_idx
);

    logic [7:0]        acc;
    logic [2:0]        bit_idx;
    logic [WIDX_W-1:0] word_cnt;

    // The word presented here includes the bit arriving this cycle, so the
    // top can register it and meet the one-cycle write latency.
    always_comb begin
        word_valid = (bit_valid && (bit_idx == 3'd7)) ||
                     (line_end && (bit_idx != 3'd0));
        word_data  = acc;
        if (bit_valid) begin
            word_data[bit_idx] = bit_in;
        end
        word_idx   = word_cnt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc      <= '0;
            bit_idx  <= '0;
            word_cnt <= '0;
        end else if (clear) begin
            acc      <= '0;
            bit_idx  <= '0;
            word_cnt <= '0;
        end else if (bit_valid) begin
            if (bit_idx == 3'd7) begin
                acc      <= '0;
                bit_idx  <= '0;
                word_cnt <= word_cnt + 1'b1;
            end else begin
                acc[bit_idx] <= bit_in;
                bit_idx      <= bit_idx + 3'd1;
            end
        end else if (line_end) begin
            acc      <= '0;
            bit_idx  <= '0;
            word_cnt <= '0;
        end
    end

endmodule

// File: rtl/edge_frame_capture.sv
// Single-shot capture of one binary edge frame into packed frame memory.
// Optional edge-pixel counter enabled by defining EDGE_CAP_COUNT_EN.
module edge_frame_capture
    import edge_cap_pkg::*;
#(
    parameter int H_RES  = 172,
    parameter int V_RES  = 144,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic              i_vsync,
    input  logic              i_de,
    input  logic [7:0]        i_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [7:0]        o_mem_wdata,
    output logic [15:0]       o_edge_cnt
);

    localparam int WPL    = ceil_div8(H_RES);
    localparam int WIDX_W = $clog2(WPL + 1);
    localparam int PIX_W  = $clog2(H_RES + 1);
    localparam int LINE_W = $clog2(V_RES + 1);

    cap_state_t        state;
    logic              vsync_q;
    logic              vsync_qq;
    logic              de_q;
    logic [PIX_W-1:0]  pix_cnt;
    logic [LINE_W-1:0] line_cnt;
    logic [ADDR_W-1:0] line_base;

    logic              boundary;
    logic              in_capture;
    logic              start_ok;
    logic              pix_ok;
    logic              line_end;
    logic              last_line;
    logic              word_valid;
    logic [7:0]        word_data;
    logic [WIDX_W-1:0] word_idx;
    logic              unused_data;

    // Only the edge bit carries information; the other bits mirror it.
    assign unused_data = ^i_data;

    assign boundary   = vsync_q & ~vsync_qq;
    assign in_capture = (state == ST_CAPTURE);
    assign start_ok   = (state == ST_IDLE) && i_start && !i_abort;
    assign pix_ok     = in_capture && i_de && (pix_cnt < PIX_W'(H_RES));
    assign line_end   = in_capture && !i_de && de_q;
    assign last_line  = line_end && (line_cnt == LINE_W'(V_RES - 1));

    edge_bit_packer #(
        .WPL    (WPL),
        .WIDX_W (WIDX_W)
    ) u_packer (
        .clk        (clk),
        .rstn       (rstn),
        .clear      (start_ok),
        .bit_valid  (pix_ok),
        .bit_in     (i_data[EDGE_BIT]),
        .line_end   (line_end),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_idx   (word_idx)
    );

    // Busy tracks the state being entered so it rises right after start and
    // falls together with the done pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            vsync_q     <= 1'b0;
            vsync_qq    <= 1'b0;
            de_q        <= 1'b0;
            pix_cnt     <= '0;
            line_cnt    <= '0;
            line_base   <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
        end else begin
            vsync_q  <= i_vsync;
            vsync_qq <= vsync_q;
            de_q     <= in_capture & i_de;
            o_mem_we <= 1'b0;
            o_done   <= 1'b0;
            if (i_abort) begin
                state  <= ST_IDLE;
                o_busy <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (i_start) begin
                            state     <= ST_ARM;
                            o_busy    <= 1'b1;
                            o_err     <= 1'b0;
                            pix_cnt   <= '0;
                            line_cnt  <= '0;
                            line_base <= '0;
                        end
                    end
                    ST_ARM: begin
                        if (boundary) begin
                            state <= ST_CAPTURE;
                        end
                    end
                    ST_CAPTURE: begin
                        if (pix_ok) begin
                            pix_cnt <= pix_cnt + 1'b1;
                        end
                        if (word_valid) begin
                            o_mem_we    <= 1'b1;
                            o_mem_addr  <= line_base + ADDR_W'(word_idx);
                            o_mem_wdata <= word_data;
                        end
                        if (line_end) begin
                            pix_cnt   <= '0;
                            line_cnt  <= line_cnt + 1'b1;
                            line_base <= line_base + ADDR_W'(WPL);
                        end
                        // Completing the last line takes precedence over a
                        // boundary landing in the same cycle.
                        if (last_line) begin
                            state <= ST_DONE;
                        end else if (boundary) begin
                            state  <= ST_IDLE;
                            o_busy <= 1'b0;
                            o_err  <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        state  <= ST_IDLE;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                    end
                    default: begin
                        state  <= ST_IDLE;
                        o_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef EDGE_CAP_COUNT_EN
    logic [15:0] edge_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            edge_cnt <= '0;
        end else if (start_ok) begin
            edge_cnt <= '0;
        end else if (pix_ok && !i_abort && i_data[EDGE_BIT] &&
                     (edge_cnt != 16'hFFFF)) begin
            edge_cnt <= edge_cnt + 16'd1;
        end
    end

    assign o_edge_cnt = edge_cnt;
`else
    assign o_edge_cnt = '0;
`endif

endmodule

// File: tb/tb_edge_frame_capture.sv
// Self-checking bench for edge_frame_capture: frame-level write model plus
// directed checks of arm wait, long lines, abort, short frame and reset.
module tb_edge_frame_capture;

    localparam int H_RES  = 172;
    localparam int V_RES  = 144;
    localparam int ADDR_W = 12;
    localparam int WPL    = 22;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              i_start = 1'b0;
    logic              i_abort = 1'b0;
    logic              i_vsync = 1'b0;
    logic              i_de = 1'b0;
    logic [7:0]        i_data = 8'h00;
    logic              o_busy;
    logic              o_done;
    logic              o_err;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [7:0]        o_mem_wdata;
    logic [15:0]       o_edge_cnt;

    always #5 clk = ~clk;

    edge_frame_capture #(
        .H_RES  (H_RES),
        .V_RES  (V_RES),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .i_start     (i_start),
        .i_abort     (i_abort),
        .i_vsync     (i_vsync),
        .i_de        (i_de),
        .i_data      (i_data),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .o_edge_cnt  (o_edge_cnt)
    );

    int         checks = 0;
    int         errors = 0;
    int         exp_addr_q[$];
    logic [7:0] exp_data_q[$];
    int         write_cnt = 0;
    int         done_cnt = 0;
    int         exp_edge = 0;
    int         last_addr = 0;
    logic       prev_we = 1'b0;
    logic [7:0] data_at_0 = 8'h00;
    logic [7:0] data_at_21 = 8'h00;
    int         mon_addr;
    logic [7:0] mon_data;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [7:0] pixel(input int mode, input int line, input int col);
        if (mode == 0) begin
            return (col % 3 == 0) ? 8'hFF : 8'h00;
        end
        return ((col >= H_RES) || (((col * 7 + line) % 11) < 4)) ? 8'hFF : 8'h00;
    endfunction

    function automatic logic [7:0] model_word(input int mode, input int line, input int w, input int cap);
        logic [7:0] word = 8'h00;
        for (int b = 0; b < 8; b++) begin
            if ((w * 8 + b) < cap && pixel(mode, line, w * 8 + b) == 8'hFF) begin
                word[b] = 1'b1;
            end
        end
        return word;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Frame-level model: every write the DUT makes must match the next
    // entry predicted from the pixels the bench drove.
    always @(negedge clk) begin
        if (rstn) begin
            if (o_mem_we) begin
                write_cnt++;
                last_addr = int'(o_mem_addr);
                if (o_mem_addr == 0) data_at_0 = o_mem_wdata;
                if (o_mem_addr == 21) data_at_21 = o_mem_wdata;
                if (exp_addr_q.size() == 0) begin
                    checkOutput("unexpected_write", 1, 0);
                end else begin
                    mon_addr = exp_addr_q.pop_front();
                    mon_data = exp_data_q.pop_front();
                    checkOutput("write_addr", o_mem_addr, mon_addr);
                    checkOutput("write_data", o_mem_wdata, mon_data);
                end
            end
            if (o_done) begin
                done_cnt++;
                checkOutput("busy_with_done", o_busy, 0);
                checkOutput("done_after_write", prev_we, 1);
            end
            prev_we = o_mem_we;
        end
    end

    // Drives one line; abort_at >= 0 raises i_abort on that pixel instead.
    task automatic applyStimulus(input int line, input int npix, input int mode,
                                 input int abort_at, input bit capturing);
        int lim = (abort_at >= 0 && abort_at < npix) ? abort_at : npix;
        int cap = (lim < H_RES) ? lim : H_RES;
        int nw  = (abort_at >= 0) ? cap / 8 : (cap + 7) / 8;
        if (capturing) begin
            for (int w = 0; w < nw; w++) begin
                exp_addr_q.push_back(line * WPL + w);
                exp_data_q.push_back(model_word(mode, line, w, cap));
            end
            for (int c = 0; c < cap; c++) begin
                if (pixel(mode, line, c) == 8'hFF) exp_edge++;
            end
        end
        for (int c = 0; c < npix; c++) begin
            i_de   = 1'b1;
            i_data = pixel(mode, line, c);
            if (c == abort_at) begin
                i_abort = 1'b1;
                tick();
                i_abort = 1'b0;
                i_de    = 1'b0;
                i_data  = 8'h00;
                tick();
                return;
            end
            tick();
        end
        i_de   = 1'b0;
        i_data = 8'h00;
        repeat (3) tick();
    endtask

    task automatic frameStart();
        i_vsync = 1'b1;
        repeat (2) tick();
        i_vsync = 1'b0;
        repeat (4) tick();
    endtask

    task automatic startCapture();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        exp_edge = 0;
    endtask

    task automatic waitDone(input int target);
        for (int i = 0; i < 50; i++) begin
            if (done_cnt >= target) break;
            tick();
        end
        checkOutput("done_count", done_cnt, target);
    endtask

    initial begin
        int w0;
        int we_seen;

        #12;
        checkOutput("rst_busy", o_busy, 0);
        checkOutput("rst_done", o_done, 0);
        checkOutput("rst_err", o_err, 0);
        checkOutput("rst_we", o_mem_we, 0);
        checkOutput("rst_addr", o_mem_addr, 0);
        checkOutput("rst_wdata", o_mem_wdata, 0);
        checkOutput("rst_edge_cnt", o_edge_cnt, 0);
        tick();
        rstn = 1'b1;
        repeat (2) tick();

        $display("[TB] start and abort together");
        i_start = 1'b1;
        i_abort = 1'b1;
        tick();
        i_start = 1'b0;
        i_abort = 1'b0;
        tick();
        checkOutput("start_abort_busy", o_busy, 0);
        frameStart();
        applyStimulus(0, 20, 0, -1, 1'b0);
        checkOutput("conflict_no_writes", write_cnt, 0);

        $display("[TB] arm wait, long lines, abort on line 50");
        startCapture();
        checkOutput("busy_after_start", o_busy, 1);
        applyStimulus(0, 40, 0, -1, 1'b0);
        checkOutput("arm_no_writes", write_cnt, 0);
        checkOutput("arm_busy", o_busy, 1);
        frameStart();
        w0 = write_cnt;
        for (int l = 0; l < 3; l++) applyStimulus(l, 180, 1, -1, 1'b1);
        checkOutput("long_line_writes", write_cnt - w0, 3 * WPL);
        for (int l = 3; l < 50; l++) applyStimulus(l, H_RES, 0, -1, 1'b1);
        applyStimulus(50, H_RES, 0, 100, 1'b1);
        we_seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (o_mem_we) we_seen++;
            tick();
        end
        checkOutput("abort_no_we", we_seen, 0);
        checkOutput("abort_busy", o_busy, 0);
        checkOutput("abort_no_done", done_cnt, 0);
        checkOutput("abort_writes", write_cnt - w0, 50 * WPL + 12);
        checkOutput("abort_queue_empty", exp_addr_q.size(), 0);

        $display("[TB] nominal frame");
        startCapture();
        frameStart();
        w0 = write_cnt;
        for (int l = 0; l < V_RES; l++) applyStimulus(l, H_RES, 0, -1, 1'b1);
        waitDone(1);
        checkOutput("frame_writes", write_cnt - w0, 3168);
        checkOutput("frame_last_addr", last_addr, 3167);
        checkOutput("frame_word0", data_at_0, 8'h49);
        checkOutput("frame_word21", data_at_21, 8'h09);
        checkOutput("frame_busy", o_busy, 0);
        checkOutput("frame_err", o_err, 0);
        checkOutput("frame_queue_empty", exp_addr_q.size(), 0);
        checkOutput("model_edge_total", exp_edge, 8352);
`ifdef EDGE_CAP_COUNT_EN
        checkOutput("edge_cnt", o_edge_cnt, exp_edge);
`else
        checkOutput("edge_cnt", o_edge_cnt, 0);
`endif
        repeat (5) tick();
        checkOutput("done_single", done_cnt, 1);

        $display("[TB] short frame");
        startCapture();
        frameStart();
        w0 = write_cnt;
        for (int l = 0; l < 100; l++) applyStimulus(l, H_RES, 0, -1, 1'b1);
        frameStart();
        checkOutput("short_err", o_err, 1);
        checkOutput("short_busy", o_busy, 0);
        checkOutput("short_writes", write_cnt - w0, 2200);
        checkOutput("short_no_done", done_cnt, 1);

        $display("[TB] error clear and async reset mid-capture");
        startCapture();
        checkOutput("err_cleared", o_err, 0);
        frameStart();
        for (int l = 0; l < 2; l++) applyStimulus(l, H_RES, 0, -1, 1'b1);
        checkOutput("pre_reset_busy", o_busy, 1);
        checkOutput("pre_reset_addr", o_mem_addr, 43);
        checkOutput("pre_reset_wdata", o_mem_wdata, 8'h09);
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("async_busy", o_busy, 0);
        checkOutput("async_err", o_err, 0);
        checkOutput("async_done", o_done, 0);
        checkOutput("async_we", o_mem_we, 0);
        checkOutput("async_addr", o_mem_addr, 0);
        checkOutput("async_wdata", o_mem_wdata, 0);
        checkOutput("async_edge_cnt", o_edge_cnt, 0);
        tick();
        rstn = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
